// File: rtl/ale_te_pkg.sv
// Shared widths, FSM state type and helpers for the ALE/TE dehazing front end.
package ale_te_pkg;

    localparam int PIX_W   = 8;
    localparam int RECIP_W = 17;
    localparam int Q_SHIFT = 8;

    typedef enum logic [1:0] {
        S_ALE,
        S_RECIP,
        S_TE
    } state_t;

    function automatic logic [PIX_W-1:0] min3(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        logic [PIX_W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/ale_te_if.sv
// Pixel stream in, transmission stream out, plus the sticky ALE-complete flag.
interface ale_te_if;
    import ale_te_pkg::*;

    logic                 en;
    logic [3*PIX_W-1:0]   input_pixel;
    logic                 input_is_valid;
    logic [PIX_W-1:0]     transmission_out;
    logic                 transmission_valid;
    logic                 done_flag;

    modport master (
        output en, input_pixel, input_is_valid,
        input  transmission_out, transmission_valid, done_flag
    );

    modport slave (
        input  en, input_pixel, input_is_valid,
        output transmission_out, transmission_valid, done_flag
    );

endinterface

// File: rtl/ale_te_recip_div.sv
// Restoring divider producing floor(65536 / max(divisor,1)); one quotient bit per cycle, 17 cycles.
module ale_recip_div
    import ale_te_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PIX_W-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [RECIP_W-1:0] quotient
);

    logic [PIX_W-1:0] dvsr;
    logic [PIX_W-1:0] rem;
    logic [4:0]       cnt;
    logic [PIX_W:0]   trial;

    // The quotient register starts as the dividend and shifts it out MSB-first
    assign trial = {rem, quotient[RECIP_W-1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvsr     <= '0;
            rem      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                dvsr     <= (divisor == '0) ? PIX_W'(1) : divisor;
                rem      <= '0;
                quotient <= RECIP_W'(1) << 16;
                cnt      <= 5'd17;
                busy     <= 1'b1;
            end else if (busy) begin
                if (trial >= {1'b0, dvsr}) begin
                    rem      <= PIX_W'(trial - {1'b0, dvsr});
                    quotient <= {quotient[RECIP_W-2:0], 1'b1};
                end else begin
                    rem      <= trial[PIX_W-1:0];
                    quotient <= {quotient[RECIP_W-2:0], 1'b0};
                end
                cnt <= cnt - 5'd1;
                if (cnt == 5'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ale_te_top.sv
// Two-pass dehazing front end: pass 1 finds atmospheric light A, pass 2 streams
// transmission t = 1 - omega*min_c(I_c/A_c) through a 3-stage pipeline.
module ale_te_top
    import ale_te_pkg::*;
#(
    parameter int NUM_PIXELS = 262144,
    parameter int OMEGA      = 240,
    parameter int T_MIN      = 25
)(
    input  logic     clk,
    input  logic     rst,
    ale_te_if.slave  bus
);

    localparam int CNT_W = $clog2(NUM_PIXELS + 1);

    state_t             state;
    logic [CNT_W-1:0]   pix_cnt;
    logic [PIX_W-1:0]   a_r, a_g, a_b, dark_max, dark;
    logic [PIX_W-1:0]   pix_r, pix_g, pix_b;
    logic               div_start, done_reg;
    logic [2:0]         div_busy, div_done;
    logic [RECIP_W-1:0] recip_r, recip_g, recip_b;
    logic               ale_accept, te_accept;

    assign pix_r      = bus.input_pixel[23:16];
    assign pix_g      = bus.input_pixel[15:8];
    assign pix_b      = bus.input_pixel[7:0];
    assign dark       = min3(pix_r, pix_g, pix_b);
    assign ale_accept = (state == S_ALE) && bus.input_is_valid && !bus.en;
    assign te_accept  = (state == S_TE) && bus.input_is_valid && bus.en;

    // Strict compare keeps the first pixel reaching the dark-channel maximum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_ALE;
            pix_cnt   <= '0;
            a_r       <= '0;
            a_g       <= '0;
            a_b       <= '0;
            dark_max  <= '0;
            div_start <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            div_start <= 1'b0;
            case (state)
                S_ALE: begin
                    if (ale_accept) begin
                        if (pix_cnt == '0 || dark > dark_max) begin
                            a_r      <= pix_r;
                            a_g      <= pix_g;
                            a_b      <= pix_b;
                            dark_max <= dark;
                        end
                        pix_cnt <= pix_cnt + 1'b1;
                        if (pix_cnt == CNT_W'(NUM_PIXELS - 1)) begin
                            state     <= S_RECIP;
                            div_start <= 1'b1;
                        end
                    end
                end
                S_RECIP: begin
                    if ((&div_done) && !(|div_busy)) begin
                        state    <= S_TE;
                        done_reg <= 1'b1;
                    end
                end
                S_TE:    ;
                default: state <= S_ALE;
            endcase
        end
    end

    ale_recip_div u_div_r (.clk(clk), .rst(rst), .start(div_start), .divisor(a_r),
                           .busy(div_busy[2]), .done(div_done[2]), .quotient(recip_r));
    ale_recip_div u_div_g (.clk(clk), .rst(rst), .start(div_start), .divisor(a_g),
                           .busy(div_busy[1]), .done(div_done[1]), .quotient(recip_g));
    ale_recip_div u_div_b (.clk(clk), .rst(rst), .start(div_start), .divisor(a_b),
                           .busy(div_busy[0]), .done(div_done[0]), .quotient(recip_b));

    function automatic logic [PIX_W-1:0] norm(input logic [PIX_W-1:0]   i,
                                              input logic [RECIP_W-1:0] r);
        logic [24:0] q;
        q = (25'(i) * 25'(r)) >> Q_SHIFT;
        return (q > 25'd255) ? 8'd255 : q[PIX_W-1:0];
    endfunction

    logic               s1_valid, s2_valid, out_valid;
    logic [PIX_W-1:0]   n_r, n_g, n_b, t_s2, t_out;
    logic [15:0]        m_omega;

    assign m_omega = 16'(min3(n_r, n_g, n_b)) * 16'(OMEGA);

    // Stage 1 normalises by A, stage 2 applies omega, stage 3 clamps to T_MIN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            n_r       <= '0;
            n_g       <= '0;
            n_b       <= '0;
            t_s2      <= '0;
            t_out     <= '0;
        end else begin
            s1_valid  <= te_accept;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (te_accept) begin
                n_r <= norm(pix_r, recip_r);
                n_g <= norm(pix_g, recip_g);
                n_b <= norm(pix_b, recip_b);
            end
            if (s1_valid)
                t_s2 <= 8'd255 - PIX_W'(m_omega >> Q_SHIFT);
            if (s2_valid)
                t_out <= (t_s2 < PIX_W'(T_MIN)) ? PIX_W'(T_MIN) : t_s2;
        end
    end

    assign bus.transmission_out   = t_out;
    assign bus.transmission_valid = out_valid;
    assign bus.done_flag          = done_reg;

endmodule

// File: tb/tb_ale_te_top.sv
// Randomised two-pass bench for ale_te_top with a queue scoreboard and a frame-level reference model.
module tb_ale_te_top;
    import ale_te_pkg::*;

    localparam int NP = 32;

    typedef struct {
        int t;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ale_te_if bus();

    ale_te_top #(.NUM_PIXELS(NP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;
    int          last_t = 0;
    exp_t        sb[$];
    logic [23:0] frame [NP];
    int          a_r, a_g, a_b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int min3i(input int x, input int y, input int z);
        int m;
        m = (x < y) ? x : y;
        return (m < z) ? m : z;
    endfunction

    // Atmospheric light: first pixel holding the largest min(R,G,B)
    function automatic void model_ale();
        int best;
        int d;
        best = -1;
        for (int i = 0; i < NP; i++) begin
            d = min3i(int'(frame[i][23:16]), int'(frame[i][15:8]), int'(frame[i][7:0]));
            if (d > best) begin
                best = d;
                a_r  = int'(frame[i][23:16]);
                a_g  = int'(frame[i][15:8]);
                a_b  = int'(frame[i][7:0]);
            end
        end
    endfunction

    function automatic int model_t(input logic [23:0] p);
        int ch[3];
        int ac[3];
        int r, n, m, t;
        ch[0] = int'(p[23:16]); ch[1] = int'(p[15:8]); ch[2] = int'(p[7:0]);
        ac[0] = a_r; ac[1] = a_g; ac[2] = a_b;
        m = 255;
        for (int c = 0; c < 3; c++) begin
            r = 65536 / ((ac[c] == 0) ? 1 : ac[c]);
            n = (ch[c] * r) / 256;
            if (n > 255) n = 255;
            if (n < m) m = n;
        end
        t = 255 - (m * 240) / 256;
        return (t < 25) ? 25 : t;
    endfunction

    task automatic applyStimulus(input logic v, input logic e, input logic [23:0] p, input bit expect_out);
        exp_t x;
        @(posedge clk);
        #1;
        bus.input_is_valid = v;
        bus.en             = e;
        bus.input_pixel    = p;
        if (expect_out) begin
            x.t   = model_t(p);
            x.cyc = cyc + 3;
            sb.push_back(x);
        end
    endtask

    task automatic do_reset();
        #2;
        rst                = 1'b0;
        bus.input_is_valid = 1'b0;
        bus.en             = 1'b0;
        bus.input_pixel    = '0;
        sb.delete();
        last_t = 0;
        #1;
        checkOutput("rst_t_out", int'(bus.transmission_out), 0);
        checkOutput("rst_t_valid", int'(bus.transmission_valid), 0);
        checkOutput("rst_done", int'(bus.done_flag), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic run_frame(input int kind, input int p2_len);
        logic [7:0] r, g, b;
        int         c_last;
        for (int i = 0; i < NP; i++) begin
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            case (kind)
                1:       begin r = 8'($urandom_range(80, 120)); g = 8'($urandom_range(80, 120)); b = 8'($urandom_range(80, 120)); end
                2:       begin r = 8'd200; g = 8'd200; b = 8'd200; end
                3:       begin r = 8'd0; g = 8'd0; b = 8'd0; end
                4:       begin r = 8'($urandom_range(0, 60)); g = 8'($urandom_range(0, 60)); b = 8'($urandom_range(0, 60)); end
                default: ;
            endcase
            frame[i] = {r, g, b};
        end
        if (kind == 3) frame[NP/2] = {8'd10, 8'd250, 8'd240};
        if (kind == 4) begin
            frame[5]  = {8'd100, 8'd90, 8'd95};
            frame[20] = {8'd90, 8'd120, 8'd90};
        end
        model_ale();

        for (int i = 0; i < NP; i++) begin
            while ($urandom_range(0, 3) == 0)
                applyStimulus($urandom_range(0, 1) == 1, 1'b1, 24'($urandom), 1'b0);
            if (i == NP - 1)
                checkOutput("done_early", int'(bus.done_flag), 0);
            applyStimulus(1'b1, 1'b0, frame[i], 1'b0);
        end
        c_last = cyc;
        repeat (3) applyStimulus(1'b1, 1'b1, 24'($urandom), 1'b0);
        applyStimulus(1'b1, 1'b0, 24'($urandom), 1'b0);
        while (!bus.done_flag && cyc < c_last + 21)
            applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
        checkOutput("done_rise", int'(bus.done_flag), 1);

        for (int i = 0; i < p2_len; i++) begin
            while ($urandom_range(0, 3) == 0)
                applyStimulus($urandom_range(0, 1) == 1, 1'b0, 24'($urandom), 1'b0);
            applyStimulus(1'b1, 1'b1, frame[i], 1'b1);
        end
        if (p2_len == NP) begin
            repeat (5) applyStimulus(1'b0, 1'b1, 24'h0, 1'b0);
            checkOutput("drain", sb.size(), 0);
            checkOutput("done_sticky", int'(bus.done_flag), 1);
        end
    endtask

    // Monitor: pops the scoreboard on each strobe, otherwise checks the output holds
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (bus.transmission_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("t_value", int'(bus.transmission_out), e.t);
                    checkOutput("latency", cyc, e.cyc);
                    last_t = e.t;
                end
            end else begin
                checkOutput("hold_value", int'(bus.transmission_out), last_t);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.en             = 1'b0;
        bus.input_is_valid = 1'b0;
        bus.input_pixel    = '0;
        do_reset();
        run_frame(2, NP);
        do_reset();
        run_frame(3, NP);
        do_reset();
        run_frame(4, NP);
        do_reset();
        run_frame(1, NP);
        do_reset();
        run_frame(0, NP / 2);
        applyStimulus(1'b0, 1'b1, 24'h0, 1'b0);
        do_reset();
        run_frame(0, NP);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
